memory_address_unit: RTL and testbench

MEMORY_ADDRESS_UNIT -- requirements
Module: memory_address_unit

---
 rtl/memory_address_unit_pkg.sv | 13 +
 rtl/memory_address_unit_if.sv | 34 +++
 rtl/memory_address_unit_fsm.sv | 83 ++++++++
 rtl/memory_address_unit.sv | 84 ++++++++
 tb/tb_memory_address_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/memory_address_unit_pkg.sv
// Shared types and default sizing for the memory address unit.
package mem_addr_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_BUS_W  = 8;

  // Burst sequencer states.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_e;

endpackage : mem_addr_pkg

// File: rtl/memory_address_unit_if.sv
// Control, bus and status signals of the memory address unit.
// The master modport drives the requests; the slave modport is the unit itself.
interface memory_address_unit_if #(
  parameter int ADDR_W = 4,
  parameter int BUS_W  = 8
);

  logic              read_from_bus;
  logic [BUS_W-1:0]  bus;
  logic              inc;
  logic              manual_mode;
  logic              manual_read;
  logic [ADDR_W-1:0] manual_switches;
  logic              burst_start;
  logic [ADDR_W-1:0] burst_len;
  logic              burst_ready;
  logic [ADDR_W-1:0] address;
  logic              burst_busy;
  logic              burst_done;
  logic              wrap;

  modport master (
    output read_from_bus, bus, inc, manual_mode, manual_read, manual_switches,
           burst_start, burst_len, burst_ready,
    input  address, burst_busy, burst_done, wrap
  );

  modport slave (
    input  read_from_bus, bus, inc, manual_mode, manual_read, manual_switches,
           burst_start, burst_len, burst_ready,
    output address, burst_busy, burst_done, wrap
  );

endinterface : memory_address_unit_if

// File: rtl/memory_address_unit_fsm.sv
// Burst sequencer: owns the IDLE/BURST state, the remaining-count register
// and the busy/done status. Tells the datapath when a burst step increments.
module mau_burst_fsm
  import mem_addr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              manual_mode_i,
  input  logic              read_from_bus_i,
  input  logic              burst_start_i,
  input  logic [ADDR_W-1:0] burst_len_i,
  input  logic              burst_ready_i,
  output logic              burst_inc_o,
  output logic              burst_busy_o,
  output logic              burst_done_o
);

  burst_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic              burst_inc_s;

  // Next-state decode: burst acceptance, handshakes, manual abort.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    burst_inc_s = 1'b0;
    case (state_q)
      IDLE: begin
        // Bus load outranks burst start; manual mode blocks both.
        if (!manual_mode_i && !read_from_bus_i && burst_start_i) begin
          state_d = BURST;
          cnt_d   = burst_len_i;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (manual_mode_i) begin
          // Abort: keep count and address, no completion pulse.
          state_d = IDLE;
        end else if (burst_ready_i) begin
          if (cnt_q != {ADDR_W{1'b0}}) begin
            burst_inc_s = 1'b1;
            cnt_d       = cnt_q - {{(ADDR_W-1){1'b0}}, 1'b1};
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = BURST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, count and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {ADDR_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == BURST);
      done_q  <= done_d;
    end
  end

  assign burst_inc_o  = burst_inc_s;
  assign burst_busy_o = busy_q;
  assign burst_done_o = done_q;

endmodule : mau_burst_fsm

// File: rtl/memory_address_unit.sv
// Memory address register with bus load, increment, manual override and
// auto-incrementing bursts. The manual override bypasses the register
// combinationally so the switches are visible even while in reset.
module memory_address_unit
  import mem_addr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BUS_W  = DEF_BUS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  memory_address_unit_if.slave   io
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap_q, wrap_d;
  logic              incr_s;
  logic              burst_inc_s;
  logic              burst_busy_s;
  logic              burst_done_s;
  logic [BUS_W-1:0]  bus_s;

  assign bus_s = io.bus;

  mau_burst_fsm #(
    .ADDR_W (ADDR_W)
  ) u_fsm (
    .clk             (clk),
    .rst             (rst),
    .manual_mode_i   (io.manual_mode),
    .read_from_bus_i (io.read_from_bus),
    .burst_start_i   (io.burst_start),
    .burst_len_i     (io.burst_len),
    .burst_ready_i   (io.burst_ready),
    .burst_inc_o     (burst_inc_s),
    .burst_busy_o    (burst_busy_s),
    .burst_done_o    (burst_done_s)
  );

  // Address register next value; busy flag mirrors the BURST state.
  always_comb begin
    addr_d = addr_q;
    incr_s = 1'b0;
    if (burst_busy_s) begin
      // Only burst handshakes move the register during a burst.
      incr_s = burst_inc_s;
    end else if (io.manual_mode) begin
      if (io.manual_read) begin
        addr_d = io.manual_switches;
      end else begin
        addr_d = addr_q;
      end
    end else if (io.read_from_bus) begin
      addr_d = bus_s[ADDR_W-1:0];
    end else if (io.burst_start) begin
      addr_d = addr_q;
    end else begin
      incr_s = io.inc;
    end
    if (incr_s) begin
      addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      wrap_d = (addr_q == {ADDR_W{1'b1}});
    end else begin
      wrap_d = 1'b0;
    end
  end

  // Address register and wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= {ADDR_W{1'b0}};
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      wrap_q <= wrap_d;
    end
  end

  assign io.address    = io.manual_mode ? io.manual_switches : addr_q;
  assign io.burst_busy = burst_busy_s;
  assign io.burst_done = burst_done_s;
  assign io.wrap       = wrap_q;

endmodule : memory_address_unit

// File: tb/tb_memory_address_unit.sv
// Directed, table-driven bench for memory_address_unit (ADDR_W=4, BUS_W=8).
module tb_memory_address_unit;

  typedef struct {
    logic       rst;
    logic       rfb;
    logic [7:0] bus;
    logic       inc;
    logic       mm;
    logic       mr;
    logic [3:0] sw;
    logic       bs;
    logic [3:0] bl;
    logic       br;
    logic [3:0] e_addr;
    logic       e_busy;
    logic       e_done;
    logic       e_wrap;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t vq[$];

  memory_address_unit_if #(.ADDR_W(4), .BUS_W(8)) mif ();

  memory_address_unit #(.ADDR_W(4), .BUS_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic rfb, input logic [7:0] b,
                     input logic inc, input logic mm, input logic mr,
                     input logic [3:0] sw, input logic bs, input logic [3:0] bl,
                     input logic br, input logic [3:0] ea, input logic eb,
                     input logic ed, input logic ew);
    vec_t v;
    v.rst = r; v.rfb = rfb; v.bus = b; v.inc = inc; v.mm = mm; v.mr = mr;
    v.sw = sw; v.bs = bs; v.bl = bl; v.br = br;
    v.e_addr = ea; v.e_busy = eb; v.e_done = ed; v.e_wrap = ew;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst                 = v.rst;
    mif.read_from_bus   = v.rfb;
    mif.bus             = v.bus;
    mif.inc             = v.inc;
    mif.manual_mode     = v.mm;
    mif.manual_read     = v.mr;
    mif.manual_switches = v.sw;
    mif.burst_start     = v.bs;
    mif.burst_len       = v.bl;
    mif.burst_ready     = v.br;
  endtask

  task automatic idle_inputs();
    vec_t v;
    v = '{default: '0};
    drive(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int cycles;
    total = 0;
    bad   = 0;
    idle_inputs();

    //   rst rfb bus   inc mm mr sw   bs bl   br   addr busy done wrap
    add(1, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h0, 0, 0, 0);
    add(1, 1, 8'hA7, 1, 0, 0, 4'h0, 1, 4'h2, 1,  4'h0, 0, 0, 0); // reset wins
    add(0, 1, 8'hA7, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h7, 0, 0, 0); // bus load low nibble
    add(0, 0, 8'h00, 1, 0, 0, 4'h0, 0, 4'h0, 0,  4'h8, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 4'h0, 0, 4'h0, 0,  4'h9, 0, 0, 0);
    add(0, 1, 8'h0F, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'hF, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 4'h0, 0, 4'h0, 0,  4'h0, 0, 0, 1); // wrap pulse
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h0, 0, 0, 0);
    add(0, 1, 8'h03, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h3, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 1, 4'h2, 0,  4'h3, 1, 0, 0); // burst accepted
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h4, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h4, 1, 0, 0); // stall
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h5, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h5, 0, 1, 0); // final handshake
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h5, 0, 0, 0);
    add(0, 1, 8'h52, 1, 0, 0, 4'h0, 1, 4'h3, 0,  4'h2, 0, 0, 0); // simultaneous
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h2, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 1, 4'h5, 0,  4'h2, 1, 0, 0);
    add(0, 1, 8'hEE, 1, 0, 1, 4'h9, 1, 4'h0, 1,  4'h3, 1, 0, 0); // others ignored in burst
    add(0, 0, 8'h00, 0, 1, 0, 4'hC, 0, 4'h0, 1,  4'hC, 0, 0, 0); // manual abort
    add(0, 0, 8'h00, 0, 1, 1, 4'hC, 0, 4'h0, 0,  4'hC, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'hC, 0, 0, 0); // register holds C
    add(0, 1, 8'h09, 1, 1, 0, 4'h5, 1, 4'h2, 0,  4'h5, 0, 0, 0); // manual blocks requests
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'hC, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 1, 4'h1, 0,  4'hC, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 1,  4'hD, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h0, 0, 0, 0); // reset mid-burst
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 1, 0, 4'h6, 0, 4'h0, 0,  4'h6, 0, 0, 0); // manual visible in reset
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h0, 0, 0, 0);
    add(0, 1, 8'h0E, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'hE, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 1, 4'h2, 0,  4'hE, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 1,  4'hF, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h0, 1, 0, 1); // burst wraps
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 1, 4'h0, 0,  4'h0, 1, 0, 0); // single-address burst
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 1,  4'h0, 0, 1, 0);
    add(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 0,  4'h0, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i]);
      step();
      check($sformatf("v%0d.address", i), {4'h0, mif.address},    {4'h0, vq[i].e_addr});
      check($sformatf("v%0d.busy", i),    {7'h0, mif.burst_busy}, {7'h0, vq[i].e_busy});
      check($sformatf("v%0d.done", i),    {7'h0, mif.burst_done}, {7'h0, vq[i].e_done});
      check($sformatf("v%0d.wrap", i),    {7'h0, mif.wrap},       {7'h0, vq[i].e_wrap});
    end

    // Manual override is combinational: visible before any clock edge.
    idle_inputs();
    mif.read_from_bus = 1'b1; mif.bus = 8'h02;
    step();
    idle_inputs();
    mif.burst_start = 1'b1; mif.burst_len = 4'h3;
    step();
    idle_inputs();
    mif.manual_mode = 1'b1; mif.manual_switches = 4'hA;
    #1;
    check("comb_manual", {4'h0, mif.address}, 8'h0A);
    mif.manual_mode = 1'b0;
    #1;
    check("comb_release", {4'h0, mif.address}, 8'h02);

    // Long stall: burst must hold with no timeout.
    for (int k = 0; k < 20; k++) step();
    check("stall_busy", {7'h0, mif.burst_busy}, 8'h01);
    check("stall_addr", {4'h0, mif.address}, 8'h02);

    // Burst of len+1 = 4 addresses completes in exactly 4 handshakes.
    mif.burst_ready = 1'b1;
    cycles = 0;
    while (mif.burst_busy && cycles < 20) begin
      step();
      cycles++;
    end
    check("hs_count", cycles[7:0], 8'd4);
    check("hs_done", {7'h0, mif.burst_done}, 8'h01);
    check("hs_addr", {4'h0, mif.address}, 8'h05);
    mif.burst_ready = 1'b0;
    step();
    check("hs_done_clr", {7'h0, mif.burst_done}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_memory_address_unit
